// File: rtl/m3_sopc_pio_pkg.sv
// Shared constants and helpers for the m3_sopc parametrised PIO input port.
package m3_sopc_pio_pkg;

  // Per-channel register offsets (address bits [1:0]).
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_EDGE = 2'd2,
    REG_RSVD = 2'd3
  } reg_sel_e;

  // Edge capture modes for the EDGE_MODE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/m3_sopc_pio_chan.sv
// One input channel: synchroniser, edge detect, MASK and sticky W1C EDGE register.
module m3_sopc_pio_chan
  import m3_sopc_pio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_bits,
  input  logic              armed,
  input  logic              mask_we,
  input  logic              edge_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] edge_cap,
  output logic              irq_term
);

  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] det;
  logic [DATA_W-1:0] clr;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in_bits;
  end else begin : g_sync
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];

    // Multi-flop synchroniser shift chain for the external inputs.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= in_bits;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign data = s;

  // Previous synchronised value for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else          p <= s;
  end

  // Edge detect per selected mode, suppressed until the port is armed.
  always_comb begin
    det = '0;
    if (EDGE_MODE == EDGE_FALL)     det = ~s & p;
    else if (EDGE_MODE == EDGE_ANY) det = s ^ p;
    else                            det = s & ~p;
    if (!armed) det = '0;
  end

  // Bits to clear from a write-one-to-clear access on EDGE.
  always_comb begin
    clr = '0;
    if (edge_we) clr = wdata;
  end

  // MASK register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mask <= '0;
    else if (mask_we) mask <= wdata;
  end

  // Sticky EDGE register; a new edge overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~clr) | det;
  end

  assign irq_term = |(edge_cap & mask);

endmodule

// File: rtl/m3_sopc_pio_in.sv
// Avalon-MM PIO input port: per-channel data/mask/edge registers with a level irq.
module m3_sopc_pio_in
  import m3_sopc_pio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [clog2(CHANNELS)+1:0]   address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  input  logic [CHANNELS*DATA_W-1:0]   in_port,
  output logic [31:0]                  readdata,
  output logic                         irq
);

  localparam int unsigned AW       = clog2(CHANNELS) + 2;
  localparam logic [2:0]  ARM_LAST = 3'(SYNC_STAGES + 1);

  logic [AW-1:0]     ch_idx;
  reg_sel_e          reg_sel;
  logic [2:0]        arm_cnt;
  logic              armed;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] irq_terms;
  logic [DATA_W-1:0] data_a [CHANNELS];
  logic [DATA_W-1:0] mask_a [CHANNELS];
  logic [DATA_W-1:0] edge_a [CHANNELS];
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign ch_idx       = address >> 2;
  assign reg_sel      = reg_sel_e'(address[1:0]);
  assign armed        = (arm_cnt == ARM_LAST);
  assign unused_wdata = ^writedata;

  // Saturating arm counter holding off edge capture while the synchroniser fills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign sel[c] = (32'(ch_idx) == c);

    m3_sopc_pio_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bits  (in_port[c*DATA_W +: DATA_W]),
      .armed    (armed),
      .mask_we  (write && sel[c] && (reg_sel == REG_MASK)),
      .edge_we  (write && sel[c] && (reg_sel == REG_EDGE)),
      .wdata    (writedata[DATA_W-1:0]),
      .data     (data_a[c]),
      .mask     (mask_a[c]),
      .edge_cap (edge_a[c]),
      .irq_term (irq_terms[c])
    );
  end

  // Read mux; out-of-range channels and the reserved offset return zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (sel[c]) begin
        case (reg_sel)
          REG_DATA: rd_mux[DATA_W-1:0] = data_a[c];
          REG_MASK: rd_mux[DATA_W-1:0] = mask_a[c];
          REG_EDGE: rd_mux[DATA_W-1:0] = edge_a[c];
          default:  rd_mux = '0;
        endcase
      end
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |irq_terms;
    end
  end

endmodule
